// File: rtl/fir_out_requant.sv
// fir_out_requant: output conditioning stage behind the 64-tap FIR.
// Rounds the Q2.30 accumulator to Q1.15 (round-half-up) and saturates it.
// Decimates by a run-time factor and stages kept samples into a small
// first-word-fall-through FIFO with a ready/valid sink interface.
// Sticky flags report saturation of kept samples and samples dropped on a full FIFO.
module fir_out_requant #(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 16,
  parameter int SHIFT  = 15,
  parameter int DEPTH  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [DIN_W-1:0]           din,
  input  logic                              din_valid,
  input  logic        [3:0]                 decim,
  input  logic                              clr_flags,
  output logic signed [DOUT_W-1:0]          dout,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic        [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                              sat_flag,
  output logic                              ovf_flag
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int EXT_W = DIN_W + 1;

  // One extra bit of headroom so adding the rounding bias cannot wrap.
  localparam logic signed [EXT_W-1:0] ROUND_BIAS = EXT_W'(1) << (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX    = EXT_W'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN    = ~SAT_MAX;

  logic signed [EXT_W-1:0]  din_ext;
  logic signed [EXT_W-1:0]  rounded;
  logic signed [DOUT_W-1:0] req_data;
  logic                     req_sat;

  logic [3:0]  dec_cnt;
  logic [3:0]  decim_eff;
  logic        keep;

  logic                     stage_valid;
  logic signed [DOUT_W-1:0] stage_data;

  logic signed [DOUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic                     empty;
  logic                     full;
  logic                     do_read;
  logic                     do_write;
  logic                     drop;

  assign din_ext = {din[DIN_W-1], din};

  // Round half-up, shift to Q1.15, then clamp to the output range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_data = '0;
    req_sat  = 1'b0;
    rounded  = (din_ext + ROUND_BIAS) >>> SHIFT;
    if (rounded > SAT_MAX) begin
      req_data = {1'b0, {(DOUT_W-1){1'b1}}};
      req_sat  = 1'b1;
    end else if (rounded < SAT_MIN) begin
      req_data = {1'b1, {(DOUT_W-1){1'b0}}};
      req_sat  = 1'b1;
    end else begin
      req_data = rounded[DOUT_W-1:0];
    end
  end

  assign decim_eff = (decim == 4'd0) ? 4'd1 : decim;
  assign keep      = din_valid && (dec_cnt == 4'd0);

  // Decimation counter: advances per valid, wraps once it reaches decim_eff-1 or beyond.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      dec_cnt <= 4'd0;
    end else if (din_valid) begin
      dec_cnt <= (dec_cnt >= decim_eff - 4'd1) ? 4'd0 : dec_cnt + 4'd1;
    end
  end

  // Stage register: captures each kept sample for one cycle before the FIFO write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= keep;
      if (keep) stage_data <= req_data;
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_read  = !empty && dout_ready;
  assign do_write = stage_valid && (!full || do_read);
  assign drop     = stage_valid && full && !do_read;

  // FIFO storage: written from the stage register, read combinationally at the head.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; pointers alone define which entries are valid.
    if (do_write) mem[wr_ptr[AW-1:0]] <= stage_data;
  end

  // FIFO pointers: an extra wrap bit distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Sticky flags: a set event in the same cycle overrides clr_flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (keep && req_sat) sat_flag <= 1'b1;
      else if (clr_flags)  sat_flag <= 1'b0;
      if (drop)            ovf_flag <= 1'b1;
      else if (clr_flags)  ovf_flag <= 1'b0;
    end
  end

  // Head is forced to zero while empty so the stale array never shows on dout.
  assign dout       = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign dout_valid = !empty;
  assign fifo_level = LVL_W'(wr_ptr - rd_ptr);

endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Output conditioning stage directly downstream of the 64-tap FIR. It accepts the FIR's 32-bit signed accumulator output (Q2.30: Q1.15 samples times Q1.15 coefficients), then rounds, saturates and decimates it to 16-bit Q1.15. Results are buffered in a small first-word-fall-through FIFO with a ready/valid output toward the sink. Sticky status flags report saturation and dropped samples.

## Interface
- DIN_W, 32, input sample width (signed).
- DOUT_W, 16, output sample width (signed).
- SHIFT, 15, right-shift applied after rounding (Q2.30 to Q1.15).
- DEPTH, 8, FIFO depth in entries; must be a power of 2 and at least 2.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  DIN_W  signed sample from the FIR (`yout`).
- din_valid  in  1  sample strobe; tie high when the FIR runs every clock.
- decim  in  4  decimation factor; 0 is treated as 1.
- clr_flags  in  1  synchronous clear of sat_flag and ovf_flag.
- dout  out  DOUT_W  FIFO head sample (signed Q1.15).
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  sink accepts dout this cycle.
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- sat_flag  out  1  sticky: a kept sample saturated.
- ovf_flag  out  1  sticky: a kept sample was dropped because the FIFO was full.

## Operation
- Reset values: every output is 0, FIFO is empty, decimation counter is 0, stage register is invalid.
- Rounding:
  - Sign-extend din to DIN_W+1 bits, add 2^(SHIFT-1), arithmetic shift right by SHIFT.
  - This is round-half-up (toward +inf on exact .5).
- Saturation:
  - A result above 2^(DOUT_W-1)-1 clamps to 0x7FFF.
  - A result below -2^(DOUT_W-1) clamps to 0x8000.
  - Either clamp sets sat_flag, but only for kept samples.
- Decimation:
  - A 4-bit counter advances once per din_valid.
  - The sample is kept when counter==0.
  - The counter wraps to 0 after reaching decim_eff-1, where decim_eff = (decim==0) ? 1 : decim.
  - If decim changes so that counter >= decim_eff-1, the counter wraps on the next valid.
  - The first valid sample after reset is always kept.
- Stage register: a kept sample is registered (value + valid) at the accepting edge, then written to the FIFO at the next edge.
- FIFO: read and write pointers of $clog2(DEPTH)+1 bits with wrap-around.
  - A read occurs when dout_valid && dout_ready.
  - A write occurs when the stage register is valid and either the FIFO is not full or a read happens in the same cycle.
  - When full with no read, the staged sample is discarded and ovf_flag is set. The FIFO contents are unchanged.
  - Simultaneous read and write when full: both happen, level stays at DEPTH, nothing is dropped.
  - Simultaneous read and write when empty: the read is ignored (dout_valid is low) and the write proceeds.
  - dout_ready with dout_valid low has no effect.
- Flags:
  - sat_flag and ovf_flag stay set until clr_flags or reset.
  - If clr_flags coincides with a new set event, the set wins.
- Reset mid-operation: asynchronously empties the FIFO, invalidates the stage register, zeroes the counter and clears both flags. Samples in flight are lost.

## Timing
- Latency: a kept din with din_valid sampled at edge E0 appears on dout with dout_valid=1 after edge E1 when the FIFO was empty. This is 2 cycles from din to dout.
- Throughput: one sample per clock is sustained with decim=1 and dout_ready held high.
- fifo_level, dout_valid and dout update together after the write/read edge.
- The sat_flag set is visible after E0. The ovf_flag set is visible after the edge at which the drop occurs.
- decim is sampled every cycle. There is no registered copy.

## Test plan
- Rounding/saturation, decim=1, ready=1:
  - din 0x00004000 -> dout 0x0001; din 0x00003FFF -> 0x0000; din 0xFFFFC000 -> 0x0000; din 0xFFFF8000 -> 0xFFFF. sat_flag stays 0.
  - din 0x7FFFFFFF -> dout 0x7FFF, sat_flag=1; din 0x80000000 -> dout 0x8000.
- Decimation: decim=3, continuous valids of k<<15 for k=1..9 -> dout sequence 1,4,7, each 2 cycles after its input. decim=0 behaves as decim=1.
- Backpressure and overflow: decim=1, ready=0, 10 consecutive valid samples 1..10 -> fifo_level=8, ovf_flag=1. Then ready=1 drains 1..8 in order and the level returns to 0.
- Full with simultaneous read/write: FIFO at 8, ready=1 with a continuous input stream -> level stays 8, ovf_flag stays 0, and output order is preserved.
- Reset and flag clear:
  - Assert reset mid-stream with the FIFO at 5 -> all outputs are 0 immediately, without waiting for a clock edge.
  - After release, the first valid sample is kept and emitted 2 cycles later.
  - clr_flags pulse clears sat_flag and ovf_flag, except when it coincides with a set event, in which case the flag remains set.
